mp64_mem_arb: RTL
=================

# mp64_mem_arb

Three-master arbiter for the 64-bit CPU port of the internal memory controller. It shares that port between the CPU bus path and the byte-wide disk and NIC DMA engines. CPU traffic has priority, a starvation counter guarantees DMA progress, and the two DMA engines alternate round-robin. It sits between the bus decoder's memory side and the memory controller's CPU port, and replaces the tied-off DMA acks in the top level.

## Interface
Parameters:
- STARVE_LIMIT, 8: consecutive CPU grants tolerated while any DMA request is pending; range 1–255.
- TIMEOUT, 1024: cycles allowed from mem_req to mem_ack before forced completion (watchdog build only); range 2–65535.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req, cpu_wen  in  1  CPU-path request and write enable.
- cpu_addr, cpu_wdata  in  64  CPU-path address and write data.
- cpu_size  in  2  CPU-path access size (0=byte … 3=dword).
- cpu_rdata  out  64  read data to the CPU path.
- cpu_ack  out  1  completion pulse to the CPU path.
- disk_dma_req, disk_dma_wen  in  1  disk DMA request and write enable.
- disk_dma_addr  in  64  disk DMA byte address.
- disk_dma_wdata  in  8  disk DMA write byte.
- disk_dma_rdata  out  8  disk DMA read byte.
- disk_dma_ack  out  1  disk DMA completion pulse.
- nic_dma_req/wen/addr/wdata/rdata/ack: identical to the disk set.
- mem_req, mem_wen  out  1  request and write enable to the memory controller.
- mem_addr, mem_wdata  out  64  address and write data to the memory controller.
- mem_size  out  2  access size to the memory controller.
- mem_rdata  in  64  read data from the memory controller.
- mem_ack  in  1  completion from the memory controller.
- err_timeout  out  1  sticky watchdog flag.

## Operation
- States:
  - IDLE: no transaction open.
  - BUSY: one transaction outstanding.
- IDLE to BUSY when any request is high. On that transition:
  - Register the grant.
  - Latch the winner's addr, wdata, wen and size into the mem_* holding registers.
- Winner selection, in priority order:
  1. If starve_cnt == STARVE_LIMIT and a DMA request is high, a DMA master wins.
  2. Otherwise, if cpu_req is high, the CPU wins.
  3. Otherwise a DMA master wins.
- Choice between the two DMA masters:
  - If both request, the one not served last wins; rr_last holds the last-served DMA master and resets to NIC, so disk wins first.
  - If only one requests, it wins.
- starve_cnt (8-bit):
  - +1 on each CPU grant made while any DMA request is high, saturating at STARVE_LIMIT.
  - Cleared on any DMA grant.
- DMA transactions are driven onto the memory port as:
  - mem_size = 2'b00.
  - mem_wdata = {56'd0, wdata}.
  - Read return is mem_rdata[7:0].
- BUSY to IDLE in the cycle mem_ack is high. In that cycle:
  - The granted master's ack is high for exactly one cycle.
  - Its rdata equals mem_rdata, passed through combinationally.
- Non-granted masters' ack stays 0. Their rdata outputs are registered and hold the last value returned to that master.
- Requesters hold req and payload until ack. The arbiter works from latched copies, so a dropped request mid-transaction does not abort it; the ack still pulses.
- After an ack, a requester must drop req the following cycle, or it is treated as a new request.

## Timing
- Reset values:
  - State IDLE; mem_req 0; mem_addr/mem_wdata/mem_wen/mem_size 0.
  - All acks 0; all rdata 0; err_timeout 0.
  - starve_cnt 0; rr_last = NIC.
- Reset asserted mid-transaction abandons it immediately; no ack is issued.
- Latency:
  - Request sampled in IDLE at edge N; mem_req high from cycle N+1.
  - Ack coincides with mem_ack, earliest cycle N+1.
  - mem_req drops in the cycle after mem_ack.
- Minimum 2 cycles per transaction; back-to-back grants are separated by one IDLE cycle.
- mem_req stays high and the mem_* holding registers stay stable for the whole of BUSY.
- mem_ack while IDLE is ignored.

## Configuration
- MP64_MEM_ARB_WATCHDOG_EN defined:
  - A 16-bit counter runs in BUSY and clears on entry to BUSY.
  - At TIMEOUT cycles without mem_ack, the arbiter forces completion: granted ack pulses, its rdata reads all-ones, state returns to IDLE, and err_timeout sets.
  - err_timeout clears only on reset.
- Undefined: no counter is built, err_timeout is tied 0, and BUSY waits on mem_ack indefinitely.

## Test plan
- CPU read at 0x100 alone; memory acks 1 cycle after mem_req with mem_rdata=0x1122334455667788 → cpu_ack single pulse, cpu_rdata=0x1122334455667788, mem_size equal to cpu_size.
- Disk write of byte 0xA5 to 0x2000 alone → mem_wdata=0x00000000000000A5, mem_size=0, mem_wen=1, disk_dma_ack pulse.
- cpu_req and disk_dma_req held continuously with STARVE_LIMIT=8 → 8 CPU grants, 1 disk grant, repeating; starve_cnt returns to 0 after each disk grant.
- Disk and NIC requesting simultaneously, no CPU → grants alternate disk, NIC, disk, NIC; NIC read returns mem_rdata[7:0]=0x3C on nic_dma_rdata.
- rst_n pulsed low while BUSY with mem_ack withheld → mem_req=0 immediately, no ack, first grant after reset goes to the CPU when all three request.
- Watchdog build, TIMEOUT=16, mem_ack never asserted → ack at cycle 16 of BUSY, rdata all-ones, err_timeout=1 and held until reset.

Source files
------------

// File: rtl/mp64_mem_arb.sv
// mp64_mem_arb: shares the memory controller CPU port between the CPU path and two byte-wide DMA engines.
// CPU has priority; a starvation counter forces DMA progress; disk/NIC alternate. Watchdog: MP64_MEM_ARB_WATCHDOG_EN.
module mp64_mem_arb #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_wen_i,
  input  logic [63:0] cpu_addr_i,
  input  logic [63:0] cpu_wdata_i,
  input  logic [1:0]  cpu_size_i,
  output logic [63:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  input  logic        disk_dma_req_i,
  input  logic        disk_dma_wen_i,
  input  logic [63:0] disk_dma_addr_i,
  input  logic [7:0]  disk_dma_wdata_i,
  output logic [7:0]  disk_dma_rdata_o,
  output logic        disk_dma_ack_o,
  input  logic        nic_dma_req_i,
  input  logic        nic_dma_wen_i,
  input  logic [63:0] nic_dma_addr_i,
  input  logic [7:0]  nic_dma_wdata_i,
  output logic [7:0]  nic_dma_rdata_o,
  output logic        nic_dma_ack_o,
  output logic        mem_req_o,
  output logic        mem_wen_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [1:0]  mem_size_o,
  input  logic [63:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        err_timeout_o
);
  typedef enum logic {IDLE, BUSY} state_e;
  localparam logic [1:0] G_CPU = 2'd0, G_DISK = 2'd1, G_NIC = 2'd2;
  localparam logic [7:0] SLIM = 8'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_chk
    $error("mp64_mem_arb: STARVE_LIMIT or TIMEOUT out of range");
  end

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        rr_nic_q, rr_nic_d;
  logic [7:0]  starve_q, starve_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic [63:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  disk_rdata_q, disk_rdata_d, nic_rdata_q, nic_rdata_d;
  logic        dma_req, pick_nic, take_dma, start, done, timeout;
  logic [63:0] dma_addr, ret_data;
  logic [7:0]  dma_wdata;
  logic        dma_wen;

  assign dma_req   = disk_dma_req_i | nic_dma_req_i;
  assign pick_nic  = nic_dma_req_i & (~disk_dma_req_i | ~rr_nic_q);
  assign take_dma  = dma_req & ((starve_q == SLIM) | ~cpu_req_i);
  assign start     = (state_q == IDLE) & (cpu_req_i | dma_req);
  assign done      = (state_q == BUSY) & (mem_ack_i | timeout);
  assign ret_data  = timeout ? '1 : mem_rdata_i;
  assign dma_addr  = pick_nic ? nic_dma_addr_i : disk_dma_addr_i;
  assign dma_wdata = pick_nic ? nic_dma_wdata_i : disk_dma_wdata_i;
  assign dma_wen   = pick_nic ? nic_dma_wen_i : disk_dma_wen_i;

`ifdef MP64_MEM_ARB_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_q;
  logic        err_q;
  assign timeout       = (state_q == BUSY) & ~mem_ack_i & (wd_q == WD_LAST);
  assign err_timeout_o = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= start ? 16'd0 : (state_q == BUSY) ? wd_q + 16'd1 : wd_q;
      err_q <= err_q | timeout;
    end
`else
  assign timeout       = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= G_CPU;
      rr_nic_q     <= 1'b1;
      starve_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      size_q       <= '0;
      cpu_rdata_q  <= '0;
      disk_rdata_q <= '0;
      nic_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_nic_q     <= rr_nic_d;
      starve_q     <= starve_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      size_q       <= size_d;
      cpu_rdata_q  <= cpu_rdata_d;
      disk_rdata_q <= disk_rdata_d;
      nic_rdata_q  <= nic_rdata_d;
    end

  always_comb state_d = start ? BUSY : done ? IDLE : state_q;

  // Saturation is implicit: at SLIM with a DMA request pending, a DMA master always wins.
  always_comb begin
    gnt_d        = start ? (take_dma ? (pick_nic ? G_NIC : G_DISK) : G_CPU) : gnt_q;
    rr_nic_d     = (start & take_dma) ? pick_nic : rr_nic_q;
    starve_d     = !start ? starve_q : take_dma ? 8'd0 : starve_q + {7'd0, dma_req};
    addr_d       = !start ? addr_q : take_dma ? dma_addr : cpu_addr_i;
    wdata_d      = !start ? wdata_q : take_dma ? {56'd0, dma_wdata} : cpu_wdata_i;
    wen_d        = !start ? wen_q : take_dma ? dma_wen : cpu_wen_i;
    size_d       = !start ? size_q : take_dma ? 2'b00 : cpu_size_i;
    cpu_rdata_d  = cpu_ack_o ? ret_data : cpu_rdata_q;
    disk_rdata_d = disk_dma_ack_o ? ret_data[7:0] : disk_rdata_q;
    nic_rdata_d  = nic_dma_ack_o ? ret_data[7:0] : nic_rdata_q;
  end

  always_comb begin
    mem_req_o        = state_q == BUSY;
    mem_wen_o        = wen_q;
    mem_addr_o       = addr_q;
    mem_wdata_o      = wdata_q;
    mem_size_o       = size_q;
    cpu_ack_o        = done & (gnt_q == G_CPU);
    disk_dma_ack_o   = done & (gnt_q == G_DISK);
    nic_dma_ack_o    = done & (gnt_q == G_NIC);
    cpu_rdata_o      = cpu_ack_o ? ret_data : cpu_rdata_q;
    disk_dma_rdata_o = disk_dma_ack_o ? ret_data[7:0] : disk_rdata_q;
    nic_dma_rdata_o  = nic_dma_ack_o ? ret_data[7:0] : nic_rdata_q;
  end
endmodule
